// File: rtl/read_iq_if.sv
// Byte-stream input and paired I/Q output handshakes of the IQ deinterleaver.
// master is the deinterleaver side, slave is the FIFO side.
interface read_iq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] I_din;
  logic                  I_full;
  logic                  I_wr_en;
  logic [DATA_WIDTH-1:0] Q_din;
  logic                  Q_full;
  logic                  Q_wr_en;

  modport master (
    input  in_dout, in_empty, I_full, Q_full,
    output in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );

  modport slave (
    output in_dout, in_empty, I_full, Q_full,
    input  in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );
endinterface

// File: rtl/read_iq.sv
// Deinterleaves a little-endian byte stream (I lo, I hi, Q lo, Q hi) into
// fixed-point I/Q samples written to two FIFOs in lockstep.
module read_iq #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int BITS       = 10
) (
  input  logic      clock,
  input  logic      reset,
  read_iq_if.master bus
);

  localparam int SAMPLE_WIDTH = 2 * BYTE_WIDTH;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [3:0][BYTE_WIDTH-1:0]  bytes_q, bytes_d;

  // Sign-extend the 16-bit sample to the output width, then scale by 2^BITS.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [SAMPLE_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] ext;
    ext = DATA_WIDTH'($signed(s));
    return ext << BITS;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      cnt_q   <= 2'd0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bytes_d      = bytes_q;
    bus.in_rd_en = 1'b0;
    bus.I_wr_en  = 1'b0;
    bus.Q_wr_en  = 1'b0;
    bus.I_din    = '0;
    bus.Q_din    = '0;

    case (state_q)
      S_READ: begin
        if (!bus.in_empty) begin
          bus.in_rd_en   = 1'b1;
          bytes_d[cnt_q] = bus.in_dout;
          cnt_d          = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      // Both FIFOs must have room so the I and Q streams never drift apart.
      S_WRITE: begin
        if (!bus.I_full && !bus.Q_full) begin
          bus.I_wr_en = 1'b1;
          bus.Q_wr_en = 1'b1;
          bus.I_din   = quantize({bytes_q[1], bytes_q[0]});
          bus.Q_din   = quantize({bytes_q[3], bytes_q[2]});
          state_d     = S_READ;
        end
      end

      default: begin
        state_d = S_READ;
        cnt_d   = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_read_iq.sv
// Self-checking bench for read_iq: directed pairs plus a long randomized run
// against a byte-queue reference model.
`timescale 1ns/1ps
module tb_read_iq;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int FB = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  read_iq_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  read_iq #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .BITS(FB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  srcBytes[$];
  int          srcHead = 0;
  logic [7:0]  poppedQ[$];
  int          pairWrites = 0;
  int          totalWrites = 0;
  int          dutWrites = 0;
  int          dutPops = 0;
  logic [31:0] wrI[$];
  logic [31:0] wrQ[$];

  // Reference quantizer: signed 16-bit value times 2^FB, kept as 32-bit two's complement.
  function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    return 32'(v * (1 << FB));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model: the block is collecting bytes whenever every complete group of
  // four popped bytes has already been written out as a pair.
  always @(negedge clock) begin : compare
    bit          reading;
    bit          expRd;
    bit          expWr;
    logic [31:0] expI;
    logic [31:0] expQ;
    int          base;
    if (reset) begin
      checkOutput("reset_rd_en", 32'(bus.in_rd_en), 32'd0);
      checkOutput("reset_I_wr_en", 32'(bus.I_wr_en), 32'd0);
      checkOutput("reset_Q_wr_en", 32'(bus.Q_wr_en), 32'd0);
      checkOutput("reset_I_din", bus.I_din, 32'd0);
      checkOutput("reset_Q_din", bus.Q_din, 32'd0);
      poppedQ.delete();
      pairWrites = 0;
    end else begin
      reading = ((poppedQ.size() / 4) == pairWrites);
      expRd   = reading && !bus.in_empty;
      expWr   = !reading && !bus.I_full && !bus.Q_full;
      expI    = 32'd0;
      expQ    = 32'd0;
      if (expWr) begin
        base = 4 * pairWrites;
        expI = quant(poppedQ[base], poppedQ[base+1]);
        expQ = quant(poppedQ[base+2], poppedQ[base+3]);
      end
      checkOutput("in_rd_en", 32'(bus.in_rd_en), 32'(expRd));
      checkOutput("I_wr_en", 32'(bus.I_wr_en), 32'(expWr));
      checkOutput("Q_wr_en", 32'(bus.Q_wr_en), 32'(expWr));
      checkOutput("I_din", bus.I_din, expI);
      checkOutput("Q_din", bus.Q_din, expQ);
      if (bus.in_rd_en) dutPops++;
      if (bus.I_wr_en) begin
        dutWrites++;
        wrI.push_back(bus.I_din);
        wrQ.push_back(bus.Q_din);
      end
      if (expRd) begin
        poppedQ.push_back(srcBytes[srcHead]);
        srcHead++;
      end
      if (expWr) begin
        pairWrites++;
        totalWrites++;
      end
    end
  end

  task automatic applyStimulus(input bit e, input bit fi, input bit fq);
    @(posedge clock);
    #2;
    bus.in_empty = e || (srcHead >= srcBytes.size());
    bus.I_full   = fi;
    bus.Q_full   = fq;
    bus.in_dout  = bus.in_empty ? 8'($urandom) : srcBytes[srcHead];
  endtask

  task automatic applyReset();
    @(posedge clock);
    #2;
    reset        = 1'b1;
    bus.in_empty = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic pushPair(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    srcBytes.push_back(b0);
    srcBytes.push_back(b1);
    srcBytes.push_back(b2);
    srcBytes.push_back(b3);
  endtask

  initial begin : stimulus
    int markW;
    int markP;
    int target;
    int cycles;
    bus.in_empty = 1'b1;
    bus.I_full   = 1'b0;
    bus.Q_full   = 1'b0;
    bus.in_dout  = 8'h00;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    // Basic pair, FIFOs never full.
    markW = dutWrites;
    markP = dutPops;
    pushPair(8'h34, 8'h12, 8'hCD, 8'hAB);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("d1_writes", 32'(dutWrites - markW), 32'd1);
    checkOutput("d1_pops", 32'(dutPops - markP), 32'd4);
    checkOutput("d1_I", wrI[wrI.size()-1], 32'h0048D000);
    checkOutput("d1_Q", wrQ[wrQ.size()-1], 32'hFEAF3400);

    // Q FIFO full for 6 cycles after byte3, with more bytes waiting upstream.
    markW = dutWrites;
    markP = dutPops;
    pushPair(8'h34, 8'h12, 8'hCD, 8'hAB);
    pushPair(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
    settle();
    checkOutput("d2_stall_writes", 32'(dutWrites - markW), 32'd0);
    checkOutput("d2_stall_pops", 32'(dutPops - markP), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("d2_writes", 32'(dutWrites - markW), 32'd1);
    checkOutput("d2_pops_after", 32'(dutPops - markP), 32'd4);
    checkOutput("d2_I", wrI[wrI.size()-1], 32'h0048D000);
    checkOutput("d2_Q", wrQ[wrQ.size()-1], 32'hFEAF3400);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("d2_next_writes", 32'(dutWrites - markW), 32'd2);
    checkOutput("d2_next_I", wrI[wrI.size()-1], 32'h00884400);
    checkOutput("d2_next_Q", wrQ[wrQ.size()-1], 32'h0110CC00);

    // in_empty toggling every cycle across three extreme-value pairs.
    markW = dutWrites;
    repeat (3) pushPair(8'h00, 8'h80, 8'hFF, 8'h7F);
    for (int i = 0; i < 40; i++) applyStimulus(i % 2 == 0, 1'b0, 1'b0);
    settle();
    checkOutput("d3_writes", 32'(dutWrites - markW), 32'd3);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("d3_I", wrI[wrI.size()-k], 32'hFE000000);
      checkOutput("d3_Q", wrQ[wrQ.size()-k], 32'h01FFFC00);
    end

    // Reset mid-pair discards the partial bytes.
    srcBytes.push_back(8'h55);
    srcBytes.push_back(8'h66);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyReset();
    markW = dutWrites;
    pushPair(8'h01, 8'h00, 8'h02, 8'h00);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("d4_writes", 32'(dutWrites - markW), 32'd1);
    checkOutput("d4_I", wrI[wrI.size()-1], 32'h00000400);
    checkOutput("d4_Q", wrQ[wrQ.size()-1], 32'h00000800);

    // Randomized backpressure and starvation over 1000 pairs.
    markW  = dutWrites;
    target = totalWrites + 1000;
    for (int i = 0; i < 4004; i++) srcBytes.push_back(8'($urandom));
    cycles = 0;
    while (totalWrites < target && cycles < 40000) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 2);
      cycles++;
    end
    settle();
    checkOutput("rand_model_writes", 32'(totalWrites), 32'(target));
    checkOutput("rand_dut_writes", 32'(dutWrites - markW), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
